axi_sram_slave: RTL and testbench

- AXI4 slave memory that sits directly downstream of the core's io_master port. It consumes the AW/W/B/AR/R traffic produced by the interconnect and is used as the main-memory model in simulation and FPGA bring-up.
- Byte-strobed 64-bit storage; FIXED and INCR bursts.
- One transaction in flight at a time; round-robin choice between read and write.

---
 rtl/axi_sram_slave_pkg.sv | 33 +++
 rtl/axi_sram_slave_addr_gen.sv | 40 ++++
 rtl/axi_sram_slave.sv | 214 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, bus widths and FSM encoding for the AXI SRAM slave.
// worse_resp ranks response codes so a burst reports its most severe beat.
package axi_sram_slave_pkg;

    localparam int BUS_AXI_ADDR_W = 32;
    localparam int BUS_AXI_DATA_W = 64;
    localparam int BUS_AXI_ID_W   = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_t;

    // Severity order is DECERR > SLVERR > OKAY.
    function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
        if (a == AXI_RESP_DECERR || b == AXI_RESP_DECERR) return AXI_RESP_DECERR;
        if (a == AXI_RESP_SLVERR || b == AXI_RESP_SLVERR) return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_slave_addr_gen.sv
// Combinational burst address step and legality checks for the beat at addr.
// One instance serves both read and write bursts since only one is ever active.
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = BUS_AXI_ADDR_W,
    parameter int                    DATA_WIDTH = BUS_AXI_DATA_W,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = SRAM_BASE_ADDR
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  size_err,
    output logic                  burst_err,
    output logic                  out_of_range
);

    localparam logic [2:0]            MAX_SIZE  = 3'($clog2(DATA_WIDTH/8));
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * (DATA_WIDTH/8));

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] offset;

    always_comb begin
        step         = ADDR_WIDTH'(1) << size;
        // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
        offset       = addr - BASE_ADDR;
        out_of_range = (offset >= MEM_BYTES);
        size_err     = (size > MAX_SIZE);
        burst_err    = !(burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR);
        if (burst == AXI_BURST_INCR) begin
            next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
        end else begin
            next_addr = addr;
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI4 slave backed by a byte-strobed block RAM.
// Read and write address channels are arbitrated round-robin via prio_wr_reg.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = BUS_AXI_ADDR_W,
    parameter int                    DATA_WIDTH = BUS_AXI_DATA_W,
    parameter int                    ID_WIDTH   = BUS_AXI_ID_W,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = SRAM_BASE_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    awready,
    input  logic                    awvalid,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    output logic                    wready,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    bready,
    output logic                    bvalid,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    arready,
    input  logic                    arvalid,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    rready,
    output logic                    rvalid,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(MEM_WORDS);

    state_t                  state_reg;
    logic                    prio_wr_reg;
    logic [ID_WIDTH-1:0]     id_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [7:0]              len_reg;
    logic [2:0]              size_reg;
    logic [1:0]              burst_reg;
    logic [8:0]              count_reg;
    logic [1:0]              bresp_reg;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_q_reg;

    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    size_err;
    logic                    burst_err;
    logic                    out_of_range;

    logic                    ar_hs, aw_hs, r_hs, w_hs;
    logic                    at_last, w_extra, mem_we;
    logic [1:0]              beat_resp, w_beat_resp;
    logic [IDX_WIDTH-1:0]    rd_idx, wr_idx;
    logic [STRB_WIDTH-1:0]   lane_we;

    function automatic logic [IDX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
        return IDX_WIDTH'((a - BASE_ADDR) >> BYTE_SHIFT);
    endfunction

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .addr         (addr_reg),
        .size         (size_reg),
        .burst        (burst_reg),
        .next_addr    (next_addr),
        .size_err     (size_err),
        .burst_err    (burst_err),
        .out_of_range (out_of_range)
    );

    // Handshake outputs are held low while rst is high so no beat completes during reset.
    assign arready = !rst && (state_reg == ST_IDLE) && !(awvalid && prio_wr_reg);
    assign awready = !rst && (state_reg == ST_IDLE) && !(arvalid && !prio_wr_reg);
    assign wready  = !rst && (state_reg == ST_WDATA);
    assign bvalid  = !rst && (state_reg == ST_WRESP);
    assign rvalid  = !rst && (state_reg == ST_RDATA);

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign r_hs  = rvalid && rready;
    assign w_hs  = wvalid && wready;

    assign at_last   = (count_reg == {1'b0, len_reg});
    assign w_extra   = (count_reg > {1'b0, len_reg});
    assign beat_resp = out_of_range            ? AXI_RESP_DECERR :
                       (size_err || burst_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign w_beat_resp = worse_resp(beat_resp,
                                    (w_extra || (wlast != at_last)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    assign mem_we    = w_hs && !w_extra && !out_of_range;

    assign bid   = id_reg;
    assign rid   = id_reg;
    assign bresp = bresp_reg;
    assign rdata = (rvalid && !out_of_range) ? mem_q_reg : '0;
    assign rresp = rvalid ? beat_resp : AXI_RESP_OKAY;
    assign rlast = rvalid && at_last;

    // The RAM is read one cycle ahead: on AR acceptance or an R handshake,
    // fetch the beat that will be presented next cycle.
    always_comb begin
        wr_idx = idx_of(addr_reg);
        if (state_reg == ST_RDATA) begin
            rd_idx = r_hs ? idx_of(next_addr) : idx_of(addr_reg);
        end else begin
            rd_idx = idx_of(araddr);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane_we
            assign lane_we[gi] = mem_we && wstrb[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (lane_we[b]) begin
                mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        mem_q_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            prio_wr_reg <= 1'b0;
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            count_reg   <= '0;
            bresp_reg   <= AXI_RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ar_hs) begin
                        id_reg    <= arid;
                        addr_reg  <= araddr;
                        len_reg   <= arlen;
                        size_reg  <= arsize;
                        burst_reg <= arburst;
                        count_reg <= '0;
                        state_reg <= ST_RDATA;
                    end else if (aw_hs) begin
                        id_reg    <= awid;
                        addr_reg  <= awaddr;
                        len_reg   <= awlen;
                        size_reg  <= awsize;
                        burst_reg <= awburst;
                        count_reg <= '0;
                        bresp_reg <= AXI_RESP_OKAY;
                        state_reg <= ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        if (at_last) begin
                            prio_wr_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else begin
                            addr_reg  <= next_addr;
                            count_reg <= count_reg + 9'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        bresp_reg <= worse_resp(bresp_reg, w_beat_resp);
                        // Beats past awlen are dropped without moving the address.
                        if (!w_extra) begin
                            addr_reg  <= next_addr;
                            count_reg <= count_reg + 9'd1;
                        end
                        if (wlast) begin
                            state_reg <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bready) begin
                        prio_wr_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave against a word-array memory model.
// Each scenario task drives its own traffic and compares inline.
module tb_axi_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        awready, awvalid;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bready, bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arready, arvalid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid, rlast;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    int errors = 0;
    int checks = 0;

    logic [63:0] ref_mem [4096];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];
    logic [63:0] got_data [$];
    logic [1:0]  got_resp [$];
    logic        got_last [$];
    logic [3:0]  got_id [$];
    int          rvalid_gaps;

    always #5 clk = ~clk;

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .awready(awready), .awvalid(awvalid), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
        .arready(arready), .arvalid(arvalid), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32768);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) / 32'd8) % 32'd4096);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] size,
                                               input logic [1:0] burst);
        logic [31:0] step;
        step = 32'd1 << size;
        if (burst == 2'b01) return (a / step) * step + step;
        return a;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int nbeats, input int last_idx,
                               output logic [1:0] exp_resp);
        int rank;
        logic [31:0] a;
        rank = 0;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            if (i > int'(len)) begin
                if (rank < 1) rank = 1;
                continue;
            end
            if ((i == last_idx) != (i == int'(len)) && rank < 1) rank = 1;
            if ((size > 3'd3 || burst > 2'b01) && rank < 1) rank = 1;
            if (!in_range(a)) begin
                rank = 2;
            end else begin
                for (int b = 0; b < 8; b++)
                    if (wq_strb[i][b]) ref_mem[widx(a)][b*8 +: 8] = wq_data[i][b*8 +: 8];
            end
            a = model_next(a, size, burst);
        end
        exp_resp = (rank == 2) ? 2'b11 : (rank == 1) ? 2'b10 : 2'b00;
    endtask

    // ---------------- bus drivers ----------------
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs;
        hs = 0;
        arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        for (int c = 0; c < 300 && !hs; c++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready never seen, required handshake");
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs;
        hs = 0;
        awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        for (int c = 0; c < 300 && !hs; c++) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready never seen, required handshake");
        end
    endtask

    task automatic send_w(input int nbeats, input int last_idx);
        bit hs;
        for (int i = 0; i < nbeats; i++) begin
            hs = 0;
            wvalid = 1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == last_idx);
            for (int c = 0; c < 300 && !hs; c++) begin
                @(negedge clk); hs = wready;
                @(posedge clk); #1;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL w_timeout: beat %0d wready never seen", i);
                i = nbeats;
            end
        end
        wvalid = 0; wlast = 0;
    endtask

    task automatic wait_b(output logic [3:0] b_id, output logic [1:0] b_resp);
        bit got;
        got = 0; b_id = 'x; b_resp = 'x;
        bready = 1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (bvalid) begin got = 1; b_id = bid; b_resp = bresp; end
            @(posedge clk); #1;
        end
        bready = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid never seen");
        end
    endtask

    task automatic read_beats(input int nbeats, input bit toggle);
        int cyc;
        got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
        rvalid_gaps = 0;
        cyc = 0;
        while (got_data.size() < nbeats && cyc < 2000) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (!rvalid) rvalid_gaps++;
            if (rvalid && rready) begin
                got_data.push_back(rdata); got_resp.push_back(rresp);
                got_last.push_back(rlast); got_id.push_back(rid);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 0;
        if (got_data.size() < nbeats) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d beats, required %0d", got_data.size(), nbeats);
            while (got_data.size() < nbeats) begin
                got_data.push_back('x); got_resp.push_back('x);
                got_last.push_back('x); got_id.push_back('x);
            end
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int last_idx, output logic [3:0] b_id, output logic [1:0] b_resp);
        send_aw(id, addr, len, size, burst);
        send_w(nbeats, last_idx);
        wait_b(b_id, b_resp);
    endtask

    task automatic fill_wq(input int n, input logic [7:0] strb);
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back({$urandom(), $urandom()});
            wq_strb.push_back(strb);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({arready, awready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b required 000000",
                     {arready, awready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bid, rid, bresp, rresp, rdata} !== 76'b0) begin
            errors++;
            $display("FAIL reset_fields: bid=%h rid=%h bresp=%b rresp=%b rdata=%h, required all zero",
                     bid, rid, bresp, rresp, rdata);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if ({arready, awready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ready: got ar/aw=%b required 11", {arready, awready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write_read();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        wq_data = '{64'h1122334455667788};
        wq_strb = '{8'hFF};
        model_write(32'h8000_0010, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        do_write(4'h5, 32'h8000_0010, 8'd0, 3'd3, 2'b01, 1, 0, b_id, b_resp);
        checks++;
        if (b_resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", b_resp); end
        checks++;
        if (b_id !== 4'h5) begin errors++; $display("FAIL single_bid: got %h required 5", b_id); end
        send_ar(4'hA, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== 64'h1122334455667788) begin
            errors++; $display("FAIL single_rdata: got %h required 1122334455667788", got_data[0]);
        end
        checks++;
        if (got_last[0] !== 1'b1 || got_resp[0] !== 2'b00) begin
            errors++; $display("FAIL single_rlast_rresp: got last=%b resp=%b required 1/00", got_last[0], got_resp[0]);
        end
        checks++;
        if (got_id[0] !== 4'hA) begin errors++; $display("FAIL single_rid: got %h required a", got_id[0]); end
        $display("txn single: wrote/read 0x80000010 bresp=%b rdata=%h", b_resp, got_data[0]);
    endtask

    task automatic test_fill();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        fill_wq(64, 8'hFF);
        model_write(BASE, 8'd63, 3'd3, 2'b01, 64, 63, exp);
        do_write(4'h3, BASE, 8'd63, 3'd3, 2'b01, 64, 63, b_id, b_resp);
        checks++;
        if (b_resp !== exp) begin errors++; $display("FAIL fill_bresp: got %b required %b", b_resp, exp); end
        $display("txn fill: 64-beat INCR write words 0..63 bresp=%b", b_resp);
    endtask

    task automatic test_incr_stall();
        send_ar(4'h2, BASE, 8'd3, 3'd3, 2'b01);
        read_beats(4, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== ref_mem[i]) begin
                errors++; $display("FAIL incr_rdata[%0d]: got %h required %h", i, got_data[i], ref_mem[i]);
            end
            checks++;
            if (got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL incr_rlast[%0d]: got %b required %b", i, got_last[i], i == 3);
            end
        end
        checks++;
        if (rvalid_gaps != 0) begin
            errors++; $display("FAIL incr_rvalid_held: rvalid low %0d cycles, required 0", rvalid_gaps);
        end
        $display("txn incr_stall: 4-beat read with rready 1,0,1,0");
    endtask

    task automatic test_partial_strobe();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        wq_data = '{64'hFFFF_FFFF_FFFF_FFFF}; wq_strb = '{8'hFF};
        model_write(BASE + 32'd80, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        do_write(4'h1, BASE + 32'd80, 8'd0, 3'd3, 2'b01, 1, 0, b_id, b_resp);
        wq_data = '{64'h0}; wq_strb = '{8'h0F};
        model_write(BASE + 32'd80, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        do_write(4'h1, BASE + 32'd80, 8'd0, 3'd3, 2'b01, 1, 0, b_id, b_resp);
        send_ar(4'h1, BASE + 32'd80, 8'd0, 3'd3, 2'b01);
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
            errors++; $display("FAIL strobe_rdata: got %h required ffffffff00000000", got_data[0]);
        end
        $display("txn partial_strobe: readback %h", got_data[0]);
    endtask

    task automatic test_arbitration();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        rst = 1; @(posedge clk); #1; rst = 0;
        arvalid = 1; arid = 4'h1; araddr = BASE + 32'd16; arlen = 0; arsize = 3; arburst = 2'b01;
        awvalid = 1; awid = 4'h2; awaddr = BASE + 32'd24; awlen = 0; awsize = 3; awburst = 2'b01;
        @(negedge clk);
        checks++;
        if ({arready, awready} !== 2'b10) begin
            errors++; $display("FAIL arb_read_first: got ar/aw=%b required 10", {arready, awready});
        end
        @(posedge clk); #1;
        arvalid = 0;
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== ref_mem[2]) begin
            errors++; $display("FAIL arb_read_data: got %h required %h", got_data[0], ref_mem[2]);
        end
        arvalid = 1; arid = 4'h4; araddr = BASE + 32'd24;
        @(negedge clk);
        checks++;
        if ({arready, awready} !== 2'b01) begin
            errors++; $display("FAIL arb_write_next: got ar/aw=%b required 01", {arready, awready});
        end
        @(posedge clk); #1;
        awvalid = 0;
        fill_wq(1, 8'hFF);
        model_write(BASE + 32'd24, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        send_w(1, 0);
        wait_b(b_id, b_resp);
        checks++;
        if (b_id !== 4'h2 || b_resp !== 2'b00) begin
            errors++; $display("FAIL arb_bresp: got id=%h resp=%b required 2/00", b_id, b_resp);
        end
        send_ar(4'h4, BASE + 32'd24, 8'd0, 3'd3, 2'b01);
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== ref_mem[3]) begin
            errors++; $display("FAIL arb_pending_read: got %h required %h", got_data[0], ref_mem[3]);
        end
        $display("txn arbitration: read, write, read completed");
    endtask

    task automatic test_decerr();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        fill_wq(1, 8'hFF);
        model_write(32'h8000_1000, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        do_write(4'h6, 32'h8000_1000, 8'd0, 3'd3, 2'b01, 1, 0, b_id, b_resp);
        send_ar(4'h6, 32'h0000_1000, 8'd1, 3'd3, 2'b01);
        read_beats(2, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_resp[i] !== 2'b11 || got_data[i] !== 64'h0) begin
                errors++; $display("FAIL decerr_read[%0d]: got resp=%b data=%h required 11/0", i, got_resp[i], got_data[i]);
            end
        end
        fill_wq(1, 8'hFF);
        model_write(32'h0000_1000, 8'd0, 3'd3, 2'b01, 1, 0, exp);
        do_write(4'h6, 32'h0000_1000, 8'd0, 3'd3, 2'b01, 1, 0, b_id, b_resp);
        checks++;
        if (b_resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp: got %b required 11", b_resp); end
        send_ar(4'h6, 32'h8000_1000, 8'd0, 3'd3, 2'b01);
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== ref_mem[512]) begin
            errors++; $display("FAIL decerr_mem_intact: got %h required %h", got_data[0], ref_mem[512]);
        end
        $display("txn decerr: out-of-range read and write at 0x00001000");
    endtask

    task automatic test_wrap_slverr();
        send_ar(4'h9, BASE, 8'd3, 3'd3, 2'b10);
        read_beats(4, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_resp[i] !== 2'b10 || got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL wrap_beat[%0d]: got resp=%b last=%b required 10/%b", i, got_resp[i], got_last[i], i == 3);
            end
        end
        $display("txn wrap: 4-beat WRAP read");
    endtask

    task automatic test_wlast_errors();
        logic [3:0] b_id;
        logic [1:0] b_resp, exp;
        // wlast on beat 1 of a 4-beat burst
        fill_wq(2, 8'hFF);
        model_write(BASE + 32'd240, 8'd3, 3'd3, 2'b01, 2, 1, exp);
        do_write(4'h7, BASE + 32'd240, 8'd3, 3'd3, 2'b01, 2, 1, b_id, b_resp);
        checks++;
        if (b_resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b required 10", b_resp); end
        // three beats sent for awlen=1; the third must be dropped
        fill_wq(3, 8'hFF);
        model_write(BASE + 32'd320, 8'd1, 3'd3, 2'b01, 3, 2, exp);
        do_write(4'h8, BASE + 32'd320, 8'd1, 3'd3, 2'b01, 3, 2, b_id, b_resp);
        checks++;
        if (b_resp !== 2'b10) begin errors++; $display("FAIL extra_beat_bresp: got %b required 10", b_resp); end
        send_ar(4'h8, BASE + 32'd240, 8'd12, 3'd3, 2'b01);
        read_beats(13, 0);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (got_data[i] !== ref_mem[30 + i]) begin
                errors++; $display("FAIL wlast_mem[%0d]: got %h required %h", 30 + i, got_data[i], ref_mem[30 + i]);
            end
        end
        $display("txn wlast_errors: early wlast and extra beats");
    endtask

    task automatic test_reset_mid_burst();
        int spurious;
        send_ar(4'h6, BASE, 8'd7, 3'd3, 2'b01);
        read_beats(2, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_burst: got rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
        spurious = 0;
        repeat (4) begin @(negedge clk); if (rvalid) spurious++; end
        @(posedge clk); #1;
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL rst_no_completion: rvalid seen %0d cycles, required 0", spurious); end
        send_ar(4'h7, BASE + 32'd40, 8'd0, 3'd3, 2'b01);
        read_beats(1, 0);
        checks++;
        if (got_data[0] !== ref_mem[5] || got_id[0] !== 4'h7) begin
            errors++; $display("FAIL rst_fresh_read: got %h id=%h required %h id=7", got_data[0], got_id[0], ref_mem[5]);
        end
        $display("txn reset_mid_burst: reset during beat 2, fresh read ok");
    endtask

    task automatic test_random();
        logic [3:0]  b_id, id;
        logic [1:0]  b_resp, exp, burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] addr, a;
        for (int t = 0; t < 24; t++) begin
            id    = 4'($urandom_range(0, 15));
            len   = 8'($urandom_range(0, 7));
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 1));
            addr  = BASE + 32'($urandom_range(0, 55)) * 32'd8 + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                fill_wq(int'(len) + 1, 8'hFF);
                foreach (wq_strb[i]) wq_strb[i] = 8'($urandom());
                model_write(addr, len, size, burst, int'(len) + 1, int'(len), exp);
                do_write(id, addr, len, size, burst, int'(len) + 1, int'(len), b_id, b_resp);
                checks++;
                if (b_resp !== exp || b_id !== id) begin
                    errors++; $display("FAIL rand_write[%0d]: got resp=%b id=%h required %b id=%h", t, b_resp, b_id, exp, id);
                end
                $display("txn %0d: write addr=%h len=%0d size=%0d burst=%0d bresp=%b", t, addr, len, size, burst, b_resp);
            end else begin
                send_ar(id, addr, len, size, burst);
                read_beats(int'(len) + 1, $urandom_range(0, 1) == 1);
                a = addr;
                for (int i = 0; i <= int'(len); i++) begin
                    checks++;
                    if (got_data[i] !== ref_mem[widx(a)] || got_resp[i] !== 2'b00 ||
                        got_last[i] !== (i == int'(len)) || got_id[i] !== id) begin
                        errors++;
                        $display("FAIL rand_read[%0d] beat %0d: got data=%h resp=%b last=%b id=%h required %h/00/%b/%h",
                                 t, i, got_data[i], got_resp[i], got_last[i], got_id[i],
                                 ref_mem[widx(a)], i == int'(len), id);
                    end
                    a = model_next(a, size, burst);
                end
                $display("txn %0d: read addr=%h len=%0d size=%0d burst=%0d", t, addr, len, size, burst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_fill();
        test_incr_stall();
        test_partial_strobe();
        test_arbitration();
        test_decerr();
        test_wrap_slverr();
        test_wlast_errors();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
